// File: rtl/flow_led_sequencer_pkg.sv
// Shared encodings for the running-light sequencer: mode select and the two pattern FSMs.
package flow_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'b00,
    MODE_BAR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } bar_st_e;

  typedef enum logic {
    FWD = 1'b0,
    BWD = 1'b1
  } bnc_st_e;

endpackage

// File: rtl/flow_led_sequencer_if.sv
// Switch controls in, LED drive and step strobe out.
interface flow_led_sequencer_if #(
  parameter int N_LED = 8
);
  import flow_pkg::*;

  logic             en;
  logic             dir;
  mode_e            mode;
  logic [1:0]       speed;
  logic [N_LED-1:0] led;
  logic             step_o;

  modport master (output en, dir, mode, speed, input led, step_o);
  modport slave  (input en, dir, mode, speed, output led, step_o);
endinterface

// File: rtl/flow_led_sequencer_prescaler.sv
// Step prescaler: tick fires combinationally on the terminal count, period BASE_DIV<<speed.
// clr restarts the count and suppresses the tick; en=0 freezes the count.
module flow_prescaler #(
  parameter int BASE_DIV = 50_000_000,
  parameter int DIV_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] limit_m1;

  assign limit_m1 = (DIV_W'(BASE_DIV) << speed) - DIV_W'(1);
  // >= rather than == so a shorter period after a speed drop wraps at once
  assign tick     = en && !clr && (cnt >= limit_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/flow_led_sequencer.sv
// Running-light pattern generator: ROTATE / BAR / BOUNCE / HOLD with a registered step strobe.
// A mode change reloads the pattern and restarts the prescaler, overriding any step that cycle.
module flow_led_sequencer
  import flow_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int BASE_DIV = 50_000_000,
  parameter int DIV_W    = 32
) (
  input logic                  clk,
  input logic                  rst,
  flow_led_sequencer_if.slave  bus
);

  localparam logic [N_LED-1:0] LED_LSB = N_LED'(1);
  localparam logic [N_LED-1:0] LED_MSB = LED_LSB << (N_LED - 1);

  mode_e            mode_q, mode_n;
  bar_st_e          bar_st, bar_n;
  bnc_st_e          bnc_st, bnc_n;
  logic [N_LED-1:0] led_q, led_n;
  logic             step_q, step_n;
  logic             reload;
  logic             tick;

  assign reload = (bus.mode != mode_q);

  flow_prescaler #(
    .BASE_DIV (BASE_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .clr   (reload),
    .speed (bus.speed),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_ROTATE;
      bar_st <= FILL;
      bnc_st <= FWD;
      led_q  <= LED_LSB;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_n;
      bar_st <= bar_n;
      bnc_st <= bnc_n;
      led_q  <= led_n;
      step_q <= step_n;
    end
  end

  always_comb begin
    mode_n = mode_q;
    bar_n  = bar_st;
    bnc_n  = bnc_st;
    led_n  = led_q;
    step_n = 1'b0;
    if (reload) begin
      mode_n = bus.mode;
      case (bus.mode)
        MODE_ROTATE, MODE_BOUNCE: begin
          led_n = bus.dir ? LED_MSB : LED_LSB;
          bnc_n = bus.dir ? BWD : FWD;
        end
        MODE_BAR: begin
          led_n = '0;
          bar_n = FILL;
        end
        MODE_HOLD: ;
      endcase
    end else if (tick) begin
      step_n = 1'b1;
      case (mode_q)
        MODE_ROTATE: begin
          led_n = bus.dir ? {led_q[0], led_q[N_LED-1:1]}
                          : {led_q[N_LED-2:0], led_q[N_LED-1]};
        end
        MODE_BAR: begin
          if (bar_st == FILL) begin
            led_n = bus.dir ? {1'b1, led_q[N_LED-1:1]} : {led_q[N_LED-2:0], 1'b1};
            if (&led_n) bar_n = DRAIN;
          end else begin
            led_n = bus.dir ? {1'b0, led_q[N_LED-1:1]} : {led_q[N_LED-2:0], 1'b0};
            if (led_n == '0) bar_n = FILL;
          end
        end
        MODE_BOUNCE: begin
          // direction comes from the FSM; dir only seeds it at reload
          if (bnc_st == FWD) begin
            led_n = led_q << 1;
            if (led_n[N_LED-1]) bnc_n = BWD;
          end else begin
            led_n = led_q >> 1;
            if (led_n[0]) bnc_n = FWD;
          end
        end
        MODE_HOLD: ;
      endcase
    end
  end

  assign bus.led    = led_q;
  assign bus.step_o = step_q;

endmodule

// File: tb/tb_flow_led_sequencer.sv
// Directed literal sequences plus randomized control churn, checked every cycle against a behavioural model.
module tb_flow_led_sequencer;
  import flow_pkg::*;

  localparam int N = 8;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  flow_led_sequencer_if #(.N_LED(N)) bus ();

  flow_led_sequencer #(
    .N_LED    (N),
    .BASE_DIV (BD),
    .DIV_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] m_led   = 8'h01;
  bit         m_step  = 1'b0;
  int         m_cnt   = 0;
  mode_e      m_mode  = MODE_ROTATE;
  bit         m_drain = 1'b0;
  int         m_pos   = 0;
  int         m_dirn  = 1;

  task automatic model_step();
    case (m_mode)
      MODE_ROTATE:
        if (!bus.dir) m_led = 8'((int'(m_led) * 2) % 256 + int'(m_led) / 128);
        else          m_led = 8'(int'(m_led) / 2 + (int'(m_led) % 2) * 128);
      MODE_BAR: begin
        if (!m_drain) begin
          m_led = bus.dir ? 8'(int'(m_led) / 2 + 128) : 8'((int'(m_led) * 2 + 1) % 256);
          if (m_led == 8'hFF) m_drain = 1'b1;
        end else begin
          m_led = bus.dir ? 8'(int'(m_led) / 2) : 8'((int'(m_led) * 2) % 256);
          if (m_led == 8'h00) m_drain = 1'b0;
        end
      end
      MODE_BOUNCE: begin
        m_pos = m_pos + m_dirn;
        if (m_pos == N - 1) m_dirn = -1;
        else if (m_pos == 0) m_dirn = 1;
        m_led = 8'(1 << m_pos);
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_led = 8'h01; m_step = 1'b0; m_cnt = 0; m_mode = MODE_ROTATE;
        m_drain = 1'b0; m_pos = 0; m_dirn = 1;
      end else begin
        m_step = 1'b0;
        if (bus.mode != m_mode) begin
          m_mode = bus.mode;
          m_cnt  = 0;
          if (m_mode == MODE_ROTATE || m_mode == MODE_BOUNCE) begin
            m_pos  = bus.dir ? N - 1 : 0;
            m_dirn = bus.dir ? -1 : 1;
            m_led  = 8'(1 << m_pos);
          end else if (m_mode == MODE_BAR) begin
            m_led   = 8'h00;
            m_drain = 1'b0;
          end
        end else if (bus.en) begin
          if (m_cnt >= (BD << bus.speed) - 1) begin
            m_cnt  = 0;
            m_step = 1'b1;
            model_step();
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (bus.led !== m_led) begin
        fails++;
        $display("FAIL model_led t=%0t: dut=%h model=%h", $time, bus.led, m_led);
      end
      tests++;
      if (bus.step_o !== m_step) begin
        fails++;
        $display("FAIL model_step t=%0t: dut=%b model=%b", $time, bus.step_o, m_step);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_step(input logic [7:0] exp_led, input int exp_gap, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.step_o !== 1'b1 && n < 64);
    if (bus.step_o !== 1'b1) begin
      check({name, "_timeout"}, 32'(n), 32'(exp_gap));
    end else begin
      check({name, "_led"}, 32'(bus.led), 32'(exp_led));
      check({name, "_gap"}, 32'(n), 32'(exp_gap));
    end
  endtask

  logic [7:0] rot_exp [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] rdir_exp [4] = '{8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] bar_exp [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                               8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
  logic [7:0] bnc_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    logic [7:0] held;
    bus.en = 1'b0; bus.dir = 1'b0; bus.mode = MODE_ROTATE; bus.speed = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_led", 32'(bus.led), 32'h01);
    check("reset_step", 32'(bus.step_o), 32'h0);
    #1 rst = 1'b0; bus.en = 1'b1;

    foreach (rot_exp[i]) wait_step(rot_exp[i], 4, "rot_left");
    wait_step(8'h02, 4, "rot_pre");
    wait_step(8'h04, 4, "rot_pre");
    wait_step(8'h08, 4, "rot_pre");
    #1 bus.dir = 1'b1;
    foreach (rdir_exp[i]) wait_step(rdir_exp[i], 4, "rot_right");

    #1 bus.mode = MODE_BAR; bus.dir = 1'b0;
    @(negedge clk);
    check("bar_reload_led", 32'(bus.led), 32'h00);
    check("bar_reload_step", 32'(bus.step_o), 32'h0);
    foreach (bar_exp[i]) wait_step(bar_exp[i], 4, "bar");

    #1 bus.mode = MODE_ROTATE;
    @(negedge clk);
    check("rot_reload_led", 32'(bus.led), 32'h01);
    wait_step(8'h02, 4, "rot_again");
    repeat (3) @(negedge clk);
    #1 bus.mode = MODE_BAR;
    @(negedge clk);
    check("tc_reload_step", 32'(bus.step_o), 32'h0);
    check("tc_reload_led", 32'(bus.led), 32'h00);
    wait_step(8'h01, 4, "tc_first_bar");

    #1 bus.mode = MODE_BOUNCE; bus.speed = 2'd1;
    @(negedge clk);
    check("bnc_reload_led", 32'(bus.led), 32'h01);
    foreach (bnc_exp[i]) wait_step(bnc_exp[i], 8, "bounce");

    repeat (3) @(negedge clk);
    #1 bus.en = 1'b0;
    held = bus.led;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("freeze_step", 32'(bus.step_o), 32'h0);
      check("freeze_led", 32'(bus.led), 32'(held));
    end
    #1 bus.en = 1'b1;
    wait_step(8'h04, 5, "resume");

    #1 bus.mode = MODE_HOLD;
    @(negedge clk);
    check("hold_reload_led", 32'(bus.led), 32'h04);
    wait_step(8'h04, 8, "hold");
    wait_step(8'h04, 8, "hold");

    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1 check("rst_pulse_led", 32'(bus.led), 32'h01);
    check("rst_pulse_step", 32'(bus.step_o), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) bus.mode = mode_e'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) bus.speed = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
